// File: rtl/kernel_gen_pkg.sv
// Shared types for the kernel stream generator: kernel modes and FSM state encoding.
package kernel_gen_pkg;

  localparam logic [1:0] MODE_EDGE     = 2'd0;
  localparam logic [1:0] MODE_PREWITT  = 2'd1;
  localparam logic [1:0] MODE_IDENTITY = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  typedef enum logic [1:0] {
    KM_EDGE     = MODE_EDGE,
    KM_PREWITT  = MODE_PREWITT,
    KM_IDENTITY = MODE_IDENTITY,
    KM_RSVD     = MODE_RSVD
  } kernel_mode_t;

  typedef logic [0:0] kgen_state_t;
  localparam kgen_state_t IDLE   = 1'b0;
  localparam kgen_state_t STREAM = 1'b1;

endpackage

// File: rtl/kernel_stream_gen_coef.sv
// Combinational X/Y coefficient lookup for one (row, col) position of a KSIZE x KSIZE kernel.
module kgen_coef
  import kernel_gen_pkg::*;
#(
  parameter int KSIZE = 3,
  parameter int CW    = 5,
  parameter int SW    = 4
) (
  input  logic [$clog2(KSIZE)-1:0] row,
  input  logic [$clog2(KSIZE)-1:0] col,
  input  kernel_mode_t             mode,
  input  logic [SW-1:0]            scalar,
  output logic signed [CW-1:0]     x,
  output logic signed [CW-1:0]     y
);

  localparam int RW = $clog2(KSIZE);
  localparam logic [RW-1:0] MID = RW'((KSIZE - 1) / 2);

  function automatic logic signed [CW-1:0] neg_wrap(input logic signed [CW-1:0] v);
    return (~v) + 1'b1;
  endfunction

  logic signed [CW-1:0] s;
  logic signed [CW-1:0] wr;
  logic signed [CW-1:0] wc;

  always_comb begin
    x  = '0;
    y  = '0;
    s  = (mode == KM_EDGE) ? {{(CW-SW){1'b0}}, scalar} : CW'(1);
    wr = (row == MID) ? s : CW'(1);
    wc = (col == MID) ? s : CW'(1);
    // reserved mode falls through to identity
    if (mode == KM_EDGE || mode == KM_PREWITT) begin
      x = (col < MID) ? wr : ((col == MID) ? '0 : neg_wrap(wr));
      y = (row < MID) ? wc : ((row == MID) ? '0 : neg_wrap(wc));
    end else begin
      x = (row == MID && col == MID) ? CW'(1) : '0;
      y = x;
    end
  end

endmodule

// File: rtl/kernel_stream_gen.sv
// Streams X/Y gradient-kernel coefficient pairs row-major after a config handshake.
// Optional KGEN_REPLAY_EN adds a replay input that restarts the last latched configuration.
module kernel_stream_gen
  import kernel_gen_pkg::*;
#(
  parameter int KSIZE = 3,
  parameter int CW    = 5,
  parameter int SW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [1:0]               cfg_mode,
  input  logic [SW-1:0]            cfg_scalar,
`ifdef KGEN_REPLAY_EN
  input  logic                     replay,
`endif
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic signed [CW-1:0]     coef_x,
  output logic signed [CW-1:0]     coef_y,
  output logic [$clog2(KSIZE)-1:0] coef_row,
  output logic [$clog2(KSIZE)-1:0] coef_col,
  output logic                     coef_last,
  output logic                     busy
);

  localparam int RW = $clog2(KSIZE);
  localparam logic [RW-1:0] LAST = RW'(KSIZE - 1);

  kgen_state_t          state_q, state_n;
  kernel_mode_t         mode_q, mode_n;
  logic [SW-1:0]        scalar_q, scalar_n;
  logic [RW-1:0]        row_n, col_n;
  logic signed [CW-1:0] x_n, y_n;
  logic                 replay_req;

`ifdef KGEN_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    scalar_n = scalar_q;
    row_n    = coef_row;
    col_n    = coef_col;
    if (state_q == IDLE) begin
      // cfg_ready is low for the first cycle after reset, so it gates both entries
      if (cfg_valid && cfg_ready) begin
        mode_n   = kernel_mode_t'(cfg_mode);
        scalar_n = cfg_scalar;
        row_n    = '0;
        col_n    = '0;
        state_n  = STREAM;
      end else if (replay_req && cfg_ready) begin
        row_n   = '0;
        col_n   = '0;
        state_n = STREAM;
      end
    end else if (coef_ready) begin
      if (coef_last) begin
        row_n   = '0;
        col_n   = '0;
        state_n = IDLE;
      end else if (coef_col == LAST) begin
        col_n = '0;
        row_n = coef_row + 1'b1;
      end else begin
        col_n = coef_col + 1'b1;
      end
    end
  end

  // coefficients are looked up for the next beat so the outputs come straight from flops
  kgen_coef #(
    .KSIZE (KSIZE),
    .CW    (CW),
    .SW    (SW)
  ) u_coef (
    .row    (row_n),
    .col    (col_n),
    .mode   (mode_n),
    .scalar (scalar_n),
    .x      (x_n),
    .y      (y_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= KM_EDGE;
      scalar_q   <= '0;
      coef_row   <= '0;
      coef_col   <= '0;
      coef_x     <= '0;
      coef_y     <= '0;
      coef_last  <= 1'b0;
      coef_valid <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      scalar_q   <= scalar_n;
      coef_row   <= row_n;
      coef_col   <= col_n;
      coef_x     <= (state_n == STREAM) ? x_n : '0;
      coef_y     <= (state_n == STREAM) ? y_n : '0;
      coef_last  <= (state_n == STREAM) && (row_n == LAST) && (col_n == LAST);
      coef_valid <= (state_n == STREAM);
      busy       <= (state_n == STREAM);
      cfg_ready  <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_kernel_stream_gen.sv
// Directed self-checking bench for kernel_stream_gen (KSIZE=3 and KSIZE=5 instances).
module tb_kernel_stream_gen;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       cfg_valid, cfg_ready, coef_valid, coef_ready, coef_last, busy;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_scalar;
  logic [4:0] coef_x, coef_y;
  logic [1:0] coef_row, coef_col;
`ifdef KGEN_REPLAY_EN
  logic       replay;
  logic       p_replay;
`endif

  logic       p_cfg_valid, p_cfg_ready, p_coef_valid, p_coef_ready, p_coef_last, p_busy;
  logic [1:0] p_cfg_mode;
  logic [3:0] p_cfg_scalar;
  logic [4:0] p_coef_x, p_coef_y;
  logic [2:0] p_coef_row, p_coef_col;

  int checks = 0;
  int errors = 0;

  kernel_stream_gen #(.KSIZE(3), .CW(5), .SW(4)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_scalar(cfg_scalar),
`ifdef KGEN_REPLAY_EN
    .replay(replay),
`endif
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_x(coef_x), .coef_y(coef_y),
    .coef_row(coef_row), .coef_col(coef_col), .coef_last(coef_last), .busy(busy)
  );

  kernel_stream_gen #(.KSIZE(5), .CW(5), .SW(4)) dut5 (
    .clk(clk), .rst(rst), .cfg_valid(p_cfg_valid), .cfg_ready(p_cfg_ready),
    .cfg_mode(p_cfg_mode), .cfg_scalar(p_cfg_scalar),
`ifdef KGEN_REPLAY_EN
    .replay(p_replay),
`endif
    .coef_valid(p_coef_valid), .coef_ready(p_coef_ready), .coef_x(p_coef_x), .coef_y(p_coef_y),
    .coef_row(p_coef_row), .coef_col(p_coef_col), .coef_last(p_coef_last), .busy(p_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [3:0] s);
    cfg_mode   = m;
    cfg_scalar = s;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg_ready: got %0b want 0", cfg_ready);
    end
    checks++;
    if ({coef_valid, busy, coef_last, coef_x, coef_y, coef_row, coef_col} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b b=%0b l=%0b x=%0d y=%0d r=%0d c=%0d want all 0",
               coef_valid, busy, coef_last, coef_x, coef_y, coef_row, coef_col);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cfg_ready !== 1'b1 || coef_valid !== 1'b0 || p_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got cfg_ready=%0b coef_valid=%0b p_cfg_ready=%0b want 1 0 1",
               cfg_ready, coef_valid, p_cfg_ready);
    end
  endtask

  task automatic test_edge();
    logic [4:0] ex [0:8] = '{5'd1, 5'd0, 5'd31, 5'd2, 5'd0, 5'd30, 5'd1, 5'd0, 5'd31};
    logic [4:0] ey [0:8] = '{5'd1, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd30, 5'd31};
    send_cfg(2'd0, 4'd2);
    for (int b = 0; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last} !==
          {1'b1, ex[b], ey[b], 2'(b / 3), 2'(b % 3), (b == 8)}) begin
        errors++;
        $display("FAIL edge_beat%0d: got v=%0b x=%0d y=%0d r=%0d c=%0d l=%0b want x=%0d y=%0d last=%0b",
                 b, coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last, ex[b], ey[b], b == 8);
      end
      tick();
    end
    checks++;
    if (cfg_ready !== 1'b1 || coef_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL edge_done: got cfg_ready=%0b coef_valid=%0b busy=%0b want 1 0 0",
               cfg_ready, coef_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] ex [0:8] = '{5'd1, 5'd0, 5'd31, 5'd2, 5'd0, 5'd30, 5'd1, 5'd0, 5'd31};
    logic [4:0] ey [0:8] = '{5'd1, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd30, 5'd31};
    send_cfg(2'd0, 4'd2);
    tick();
    tick();
    tick();
    coef_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last} !==
          {1'b1, 5'd2, 5'd0, 2'd1, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b x=%0d y=%0d r=%0d c=%0d l=%0b want 1 2 0 1 0 0",
                 k, coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last);
      end
      tick();
    end
    coef_ready = 1'b1;
    tick();
    for (int b = 4; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last} !==
          {1'b1, ex[b], ey[b], 2'(b / 3), 2'(b % 3), (b == 8)}) begin
        errors++;
        $display("FAIL stall_resume%0d: got v=%0b x=%0d y=%0d r=%0d c=%0d want x=%0d y=%0d",
                 b, coef_valid, coef_x, coef_y, coef_row, coef_col, ex[b], ey[b]);
      end
      tick();
    end
  endtask

  task automatic test_zero_scalar();
    logic [4:0] ex [0:8] = '{5'd1, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd31};
    logic [4:0] ey [0:8] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd31};
    send_cfg(2'd0, 4'd0);
    for (int b = 0; b < 9; b++) begin
      if (b == 2) begin
        cfg_mode   = 2'd1;
        cfg_scalar = 4'd5;
        cfg_valid  = 1'b1;
      end
      if (b == 4) cfg_valid = 1'b0;
      checks++;
      if ({cfg_ready, coef_valid, coef_x, coef_y, coef_row, coef_col} !==
          {1'b0, 1'b1, ex[b], ey[b], 2'(b / 3), 2'(b % 3)}) begin
        errors++;
        $display("FAIL zero_scalar_beat%0d: got rdy=%0b v=%0b x=%0d y=%0d want rdy=0 x=%0d y=%0d",
                 b, cfg_ready, coef_valid, coef_x, coef_y, ex[b], ey[b]);
      end
      tick();
    end
    tick();
    checks++;
    if (coef_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_cfg_started: got coef_valid=%0b cfg_ready=%0b want 0 1",
               coef_valid, cfg_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] px [0:8] = '{5'd1, 5'd0, 5'd31, 5'd1, 5'd0, 5'd31, 5'd1, 5'd0, 5'd31};
    logic [4:0] py [0:8] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31};
    send_cfg(2'd0, 4'd2);
    for (int b = 0; b < 9; b++) tick();
    checks++;
    if (cfg_ready !== 1'b1 || coef_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble: got cfg_ready=%0b coef_valid=%0b want 1 0", cfg_ready, coef_valid);
    end
    send_cfg(2'd1, 4'd9);
    for (int b = 0; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y, coef_row, coef_col, coef_last} !==
          {1'b1, px[b], py[b], 2'(b / 3), 2'(b % 3), (b == 8)}) begin
        errors++;
        $display("FAIL b2b_prewitt%0d: got v=%0b x=%0d y=%0d r=%0d c=%0d want x=%0d y=%0d",
                 b, coef_valid, coef_x, coef_y, coef_row, coef_col, px[b], py[b]);
      end
      tick();
    end
  endtask

  task automatic test_prewitt5();
    logic [4:0] pv [0:4] = '{5'd1, 5'd1, 5'd0, 5'd31, 5'd31};
    p_cfg_mode   = 2'd1;
    p_cfg_scalar = 4'd3;
    p_cfg_valid  = 1'b1;
    tick();
    p_cfg_valid  = 1'b0;
    for (int b = 0; b < 25; b++) begin
      checks++;
      if ({p_coef_valid, p_coef_x, p_coef_y, p_coef_row, p_coef_col, p_coef_last} !==
          {1'b1, pv[b % 5], pv[b / 5], 3'(b / 5), 3'(b % 5), (b == 24)}) begin
        errors++;
        $display("FAIL prewitt5_beat%0d: got v=%0b x=%0d y=%0d r=%0d c=%0d l=%0b want x=%0d y=%0d",
                 b, p_coef_valid, p_coef_x, p_coef_y, p_coef_row, p_coef_col, p_coef_last,
                 pv[b % 5], pv[b / 5]);
      end
      tick();
    end
    checks++;
    if (p_coef_valid !== 1'b0 || p_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL prewitt5_len: got coef_valid=%0b cfg_ready=%0b after 25 beats want 0 1",
               p_coef_valid, p_cfg_ready);
    end
  endtask

  task automatic test_identity_reset();
    send_cfg(2'd2, 4'd6);
    for (int b = 0; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y} !== {1'b1, (b == 4) ? 5'd1 : 5'd0, (b == 4) ? 5'd1 : 5'd0}) begin
        errors++;
        $display("FAIL identity_beat%0d: got v=%0b x=%0d y=%0d want %0d", b, coef_valid, coef_x,
                 coef_y, b == 4);
      end
      tick();
    end
    send_cfg(2'd3, 4'd6);
    for (int b = 0; b < 5; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y} !== {1'b1, (b == 4) ? 5'd1 : 5'd0, (b == 4) ? 5'd1 : 5'd0}) begin
        errors++;
        $display("FAIL mode3_beat%0d: got v=%0b x=%0d y=%0d want %0d", b, coef_valid, coef_x,
                 coef_y, b == 4);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({coef_valid, busy, cfg_ready, coef_x, coef_row, coef_col} !== 11'd0) begin
      errors++;
      $display("FAIL midstream_reset: got v=%0b busy=%0b rdy=%0b x=%0d r=%0d c=%0d want all 0",
               coef_valid, busy, cfg_ready, coef_x, coef_row, coef_col);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cfg_ready !== 1'b1 || coef_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got cfg_ready=%0b coef_valid=%0b want 1 0", cfg_ready, coef_valid);
    end
  endtask

`ifdef KGEN_REPLAY_EN
  task automatic test_replay();
    logic [4:0] ex [0:8] = '{5'd1, 5'd0, 5'd31, 5'd7, 5'd0, 5'd25, 5'd1, 5'd0, 5'd31};
    logic [4:0] ey [0:8] = '{5'd1, 5'd7, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd25, 5'd31};
    logic [4:0] px [0:8] = '{5'd1, 5'd0, 5'd31, 5'd1, 5'd0, 5'd31, 5'd1, 5'd0, 5'd31};
    logic [4:0] py [0:8] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31};
    send_cfg(2'd0, 4'd7);
    for (int b = 0; b < 9; b++) tick();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    for (int b = 0; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y, coef_last} !== {1'b1, ex[b], ey[b], (b == 8)}) begin
        errors++;
        $display("FAIL replay_beat%0d: got v=%0b x=%0d y=%0d want x=%0d y=%0d", b, coef_valid,
                 coef_x, coef_y, ex[b], ey[b]);
      end
      tick();
    end
    replay = 1'b1;
    send_cfg(2'd1, 4'd7);
    replay = 1'b0;
    for (int b = 0; b < 9; b++) begin
      checks++;
      if ({coef_valid, coef_x, coef_y} !== {1'b1, px[b], py[b]}) begin
        errors++;
        $display("FAIL replay_vs_cfg%0d: got v=%0b x=%0d y=%0d want x=%0d y=%0d", b, coef_valid,
                 coef_x, coef_y, px[b], py[b]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_mode     = 2'd0;
    cfg_scalar   = 4'd0;
    coef_ready   = 1'b1;
    p_cfg_valid  = 1'b0;
    p_cfg_mode   = 2'd0;
    p_cfg_scalar = 4'd0;
    p_coef_ready = 1'b1;
`ifdef KGEN_REPLAY_EN
    replay       = 1'b0;
    p_replay     = 1'b0;
`endif
    test_reset();
    test_edge();
    test_backpressure();
    test_zero_scalar();
    test_back_to_back();
    test_prewitt5();
    test_identity_reset();
`ifdef KGEN_REPLAY_EN
    test_replay();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_stream_gen.md
# kernel_stream_gen

Parametrised successor to the fixed 3x3 gradient-kernel generator. Accepts a kernel configuration (mode, centre-weight scalar) over a valid/ready handshake. Streams the matching X and Y kernel coefficient pairs, row-major, one beat per cycle to the convolution engine. Supports odd kernel sizes, configurable coefficient width, and backpressure.

## Interface
- KSIZE, 3, kernel edge length; odd, 3..7
- CW, 5, coefficient width, two's complement
- SW, 4, scalar width; SW < CW required
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  block can accept configuration
- cfg_mode  in  2  kernel_mode_t: 0 EDGE, 1 PREWITT, 2 IDENTITY, 3 reserved (treated as IDENTITY)
- cfg_scalar  in  SW  unsigned centre weight (EDGE only)
- coef_valid  out  1  coefficient beat present
- coef_ready  in  1  sink accepts beat
- coef_x  out  CW  X-kernel coefficient
- coef_y  out  CW  Y-kernel coefficient
- coef_row  out  $clog2(KSIZE)  row of current beat
- coef_col  out  $clog2(KSIZE)  column of current beat
- coef_last  out  1  high on final beat (row = col = KSIZE-1)
- busy  out  1  high while a stream is in progress

## Operation
- mid = (KSIZE-1)/2.
- d[i] = +1 if i < mid, 0 if i = mid, -1 if i > mid.
- w[i] = s if i = mid, else 1.
  - s = zero-extended cfg_scalar in EDGE mode.
  - s = 1 in PREWITT mode.
- EDGE/PREWITT: x[r][c] = w[r]*d[c]; y[r][c] = d[r]*w[c].
  - Negation is two's complement modulo 2^CW: -1 = all ones, -s = (~s)+1.
- IDENTITY: x = y = 1 at (mid,mid), 0 elsewhere.
- FSM states (kgen_state_t):
  - IDLE: cfg_ready=1, coef_valid=0. On cfg_valid && cfg_ready, latch mode and scalar, clear row/col, go to STREAM.
  - STREAM: coef_valid=1, cfg_ready=0, and cfg_valid is ignored. On coef_valid && coef_ready:
    - Increment col; at col=KSIZE-1, wrap col to 0 and increment row.
    - On the beat with coef_last, go to IDLE.
- coef_valid never drops before acceptance. While stalled, coef_x/y/row/col/last are held stable.
- Reset values: cfg_ready=0 during reset, 1 in the first cycle after reset release. All other outputs 0. State IDLE, latched mode/scalar 0.
- Reset mid-stream: the stream is abandoned immediately. No partial-beat state survives.

## Timing
- Configuration accepted at edge N; beat 0 is valid from cycle N+1.
- Outputs are registered, with no combinational path from coef_ready to coef_* data.
  - Exception: coef_valid/cfg_ready are state-decoded, not derived from inputs.
- Throughput is 1 beat/cycle with coef_ready held high. A full kernel takes KSIZE*KSIZE cycles.
- Last beat accepted at edge M: cfg_ready=1 in cycle M+1, so the earliest next beat is at M+2 (one bubble).

## Configuration
- KGEN_REPLAY_EN defined:
  - Adds input port `replay` (1 bit).
  - In IDLE, replay=1 restarts STREAM with the previously latched mode and scalar. Timing is the same as a configuration accept.
  - If replay and cfg_valid are both high, cfg_valid wins and the new configuration is latched.
  - replay after reset streams with mode 0 and scalar 0.
- KGEN_REPLAY_EN undefined: no replay port exists. The only entry to STREAM is a cfg handshake.

## Structure
- Package kernel_gen_pkg holds:
  - kernel_mode_t (2-bit enum)
  - kgen_state_t (IDLE, STREAM)
  - mode encodings as localparams
- Sub-module kgen_coef: combinational.
  - Inputs: row, col, mode, scalar.
  - Outputs: x and y coefficients, computed with parameters KSIZE/CW/SW.
  - Instantiated once, driven from the next-state row/col so that outputs are registered.

## Test plan
- KSIZE=3, CW=5, EDGE, scalar=2, ready high:
  - x = 1,0,31,2,0,30,1,0,31
  - y = 1,2,1,0,0,0,31,30,31
  - coef_last only on beat 8
  - cfg_ready=1 one cycle after beat 8.
- Same configuration, coef_ready low for 3 cycles on beat 3: x=2, y=0, row=1, col=0 held stable. Stream then resumes at beat 4 (x=0, y=0).
- EDGE, scalar=0: beats 3..5 give x=0,0,0. cfg_valid pulsed mid-stream is ignored, with cfg_ready=0 throughout.
- KSIZE=5, PREWITT: row 0 x = 1,1,0,31,31; row 0 y = 1,1,1,1,1; 25 beats total.
- IDENTITY and mode 3: only beat 4 (KSIZE=3) has x=y=1. rst asserted at beat 5 drops coef_valid and busy to 0 immediately; cfg_ready=1 after release.
- With KGEN_REPLAY_EN: after an EDGE scalar=7 stream, a replay pulse re-emits the identical 9 beats. A simultaneous replay plus cfg (PREWITT) streams PREWITT.
